// File: rtl/pcx_buf_pm_pipe.sv
// Retimed PCX grant/stall buffer: STAGES-deep flop pipe on grant and stall,
// plus per-channel saturating grant counters and a sticky multi-grant flag.

module pcx_buf_pm_cnt #(
   parameter int CNTW = 8
) (
   input  logic            rclk,
   input  logic            reset_l,
   input  logic            cnt_clr,
   input  logic            inc,
   output logic [CNTW-1:0] cnt
);
   logic [CNTW-1:0] cnt_q, cnt_d;

   // Clear beats increment; saturate at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (!reset_l || cnt_clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {CNTW{1'b1}}))
         cnt_d = cnt_q + CNTW'(1);
   end

   always_ff @(posedge rclk) cnt_q <= cnt_d;

   assign cnt = cnt_q;
endmodule

module pcx_buf_pm_pipe #(
   parameter int NCH    = 5,
   parameter int STAGES = 2,
   parameter int CNTW   = 8
) (
   input  logic                 rclk,
   input  logic                 reset_l,
   input  logic [NCH-1:0]       pcx_spc_grant_pa,
   input  logic                 pcx_stall_pq,
   input  logic                 cnt_clr,
   output logic [NCH-1:0]       pcx_spc_grant_bufpm_pa,
   output logic                 pcx_stall_bufpm_pq,
   output logic [NCH*CNTW-1:0]  grant_cnt,
   output logic                 grant_err
);
   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("pcx_buf_pm_pipe: STAGES must be in 1..4");
      end
   endgenerate

   logic [STAGES-1:0][NCH-1:0] gnt_pipe_q, gnt_pipe_d;
   logic [STAGES-1:0]          stall_pipe_q, stall_pipe_d;
   logic                       err_q, err_d;
   logic                       multi_gnt;

   // Stall is plain data here; reset drops in-flight grants and fills the
   // stall pipe with 1 so consumers wait until real data reaches the end.
   always_comb begin
      gnt_pipe_d[0]   = pcx_spc_grant_pa;
      stall_pipe_d[0] = pcx_stall_pq;
      for (int k = 1; k < STAGES; k++) begin
         gnt_pipe_d[k]   = gnt_pipe_q[k-1];
         stall_pipe_d[k] = stall_pipe_q[k-1];
      end
      if (!reset_l) begin
         gnt_pipe_d   = '0;
         stall_pipe_d = '1;
      end
   end

   always_ff @(posedge rclk) begin
      gnt_pipe_q   <= gnt_pipe_d;
      stall_pipe_q <= stall_pipe_d;
   end

   assign pcx_spc_grant_bufpm_pa = gnt_pipe_q[STAGES-1];
   assign pcx_stall_bufpm_pq     = stall_pipe_q[STAGES-1];

   // More than one bit set <=> clearing the lowest set bit leaves something.
   assign multi_gnt = |(pcx_spc_grant_bufpm_pa & (pcx_spc_grant_bufpm_pa - NCH'(1)));

   always_comb begin
      err_d = err_q | multi_gnt;
      if (!reset_l || cnt_clr)
         err_d = 1'b0;
   end

   always_ff @(posedge rclk) err_q <= err_d;

   assign grant_err = err_q;

   pcx_buf_pm_cnt #(.CNTW(CNTW)) u_cnt [NCH-1:0] (
      .rclk    (rclk),
      .reset_l (reset_l),
      .cnt_clr (cnt_clr),
      .inc     (pcx_spc_grant_bufpm_pa),
      .cnt     (grant_cnt)
   );
endmodule
